// File: rtl/div_mod_sequencer.sv
// div_mod_sequencer: multi-cycle unsigned DIV/MOD controller for the EX stage.
// It runs a restoring division one quotient bit per cycle, MSB first, and
// holds the pipeline stalled while it iterates. It then pulses done for one
// cycle, with the quotient (DIV) or the remainder (MOD) on result.
// Optional feature macro: DIV_ZERO_TRAP_EN. When it is defined, a zero
// divisor skips the iteration and is reported on div_zero.
module div_mod_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic               is_mod_q;   // latched op: 1 = MOD, 0 = DIV
  logic [WIDTH-1:0]   dvd_q;      // dividend shifts out MSB-first, quotient shifts in at LSB
  logic [WIDTH-1:0]   dvs_q;      // latched divisor
  logic [WIDTH:0]     rem_q;      // partial remainder
  logic [CNT_W-1:0]   count_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;

  logic               is_divmod;
  logic               accept;
  logic [WIDTH:0]     rem_shift;
  logic               qbit;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH-1:0]   dvd_d;

  assign is_divmod = (alu_ctrl == OP_DIV) || (alu_ctrl == OP_MOD);
  assign accept    = start && is_divmod && (state_q == S_IDLE) && !flush;

  // stall covers the accept cycle combinationally so the EX instruction freezes immediately
  assign stall  = accept || (state_q == S_RUN);
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  // The rem_q MSB stays zero, because the remainder is always below the divisor.
  // It is ORed into the compare so that the bit has a consumer.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    qbit      = rem_q[WIDTH] || (rem_shift >= {1'b0, dvs_q});
    rem_d     = qbit ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
    dvd_d     = {dvd_q[WIDTH-2:0], qbit};
  end

`ifdef DIV_ZERO_TRAP_EN
  logic div_zero_q;
  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

  // Sequencer FSM with the datapath and the registered done/result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_mod_q   <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
`ifdef DIV_ZERO_TRAP_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            is_mod_q <= (alu_ctrl == OP_MOD);
            dvd_q    <= src_a;
            dvs_q    <= src_b;
            rem_q    <= '0;
            count_q  <= CNT_W'(WIDTH - 1);
`ifdef DIV_ZERO_TRAP_EN
            if (src_b == '0) begin
              // A zero divisor short-circuits to DONE with the architectural fallback values
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              div_zero_q <= 1'b1;
              result_q   <= (alu_ctrl == OP_MOD) ? src_a : '1;
            end else begin
              state_q    <= S_RUN;
              div_zero_q <= 1'b0;
            end
`else
            state_q <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          if (flush) begin
            // The killed op leaves result untouched and raises no done
            state_q <= S_IDLE;
          end else begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
            if (count_q == '0) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= is_mod_q ? rem_d[WIDTH-1:0] : dvd_d;
            end else begin
              count_q <= count_q - 1'b1;
            end
          end
        end
        S_DONE: begin
          // flush is ignored here: the result is already committed
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_mod_sequencer.sv
// Directed self-checking bench for div_mod_sequencer (WIDTH=32).
// Expectations for a zero divisor follow DIV_ZERO_TRAP_EN when it is defined.
module tb_div_mod_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;

`ifdef DIV_ZERO_TRAP_EN
  localparam int  ZLAT = 1;
  localparam bit  ZDZ  = 1'b1;
`else
  localparam int  ZLAT = 33;
  localparam bit  ZDZ  = 1'b0;
`endif

  div_mod_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current (idle) cycle, then follow it to done.
  // Ends in the cycle after done, so that the next op can be accepted back-to-back.
  task automatic run_op(input string tag, input logic [2:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input logic exp_dz, input bit poke);
    int cyc;
    bit seen;
    bit run_ok;
    start = 1'b1; alu_ctrl = ctrl; src_a = a; src_b = b; flush = 1'b0;
    #1;
    chk({tag, " accept_stall"}, 32'(stall), 32'd1);
    tick();
    start = 1'b0; alu_ctrl = 3'b000; src_a = 32'h0; src_b = 32'h0;
    cyc = 1; seen = 1'b0; run_ok = 1'b1;
    while (cyc <= 40 && !seen) begin
      #1;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (stall !== 1'b1 || busy !== 1'b1) run_ok = 1'b0;
        if (poke && (cyc == 5 || cyc == 20)) begin
          start = 1'b1; alu_ctrl = 3'b100; src_a = 32'd77; src_b = 32'd3;
        end else begin
          start = 1'b0; alu_ctrl = 3'b000;
        end
        tick();
        cyc++;
      end
    end
    start = 1'b0; alu_ctrl = 3'b000;
    chk({tag, " latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
    chk({tag, " run_stall_busy"}, 32'(run_ok), 32'd1);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " div_zero"}, 32'(div_zero), 32'(exp_dz));
    chk({tag, " done_stall"}, 32'(stall), 32'd0);
    tick();
    chk({tag, " after_done"}, {30'd0, done, busy}, 32'd0);
    $display("op %s a=%0d b=%0d result=%0d latency=%0d", tag, a, b, result, cyc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; alu_ctrl = 3'b000; src_a = '0; src_b = '0; flush = 1'b0;
    tick(); tick();
    chk("reset_outs", {27'd0, stall, busy, done, div_zero, 1'b0}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;
    tick();

    // Basic DIV/MOD, then a back-to-back DIV in the cycle after done
    run_op("div_100_7", 3'b011, 32'd100, 32'd7, 32'd14, 33, 1'b0, 1'b0);
    run_op("mod_100_7", 3'b100, 32'd100, 32'd7, 32'd2, 33, 1'b0, 1'b0);
    run_op("div_max_1", 3'b011, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b0, 1'b0);

    // Zero divisor
    run_op("div_5_0", 3'b011, 32'd5, 32'd0, 32'hFFFF_FFFF, ZLAT, ZDZ, 1'b0);
    run_op("mod_5_0", 3'b100, 32'd5, 32'd0, 32'd5, ZLAT, ZDZ, 1'b0);
    // The next accept clears div_zero
    run_op("mod_17_5", 3'b100, 32'd17, 32'd5, 32'd2, 33, 1'b0, 1'b0);

    // Flush in cycle 10 of RUN
    start = 1'b1; alu_ctrl = 3'b011; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    #1;
    chk("flush_c10_stall", 32'(stall), 32'd1);
    tick();
    flush = 1'b0;
    chk("flush_c11_idle", {29'd0, stall, busy, done}, 32'd0);
    chk("flush_result_kept", result, 32'd2);
    tick();
    chk("flush_no_done", {31'd0, done}, 32'd0);
    $display("op flush_div result=%0d busy=%0b", result, busy);

    // flush coincident with start: no accept
    start = 1'b1; alu_ctrl = 3'b011; flush = 1'b1;
    #1;
    chk("flush_start_stall", 32'(stall), 32'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    $display("op flush_with_start busy=%0b", busy);

    // Asynchronous reset between edges in the middle of RUN
    start = 1'b1; alu_ctrl = 3'b011; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_outs", {27'd0, stall, busy, done, div_zero, 1'b0}, 32'd0);
    chk("arst_result", result, 32'd0);
    #1 rst = 1'b0;
    tick();
    $display("op async_reset busy=%0b result=%0d", busy, result);
    run_op("mod_9_4", 3'b100, 32'd9, 32'd4, 32'd1, 33, 1'b0, 1'b0);

    // Non-DIV/MOD codes are ignored
    start = 1'b1; alu_ctrl = 3'b000; src_a = 32'd50; src_b = 32'd5;
    #1;
    chk("ctrl000_stall", 32'(stall), 32'd0);
    tick();
    chk("ctrl000_busy", {30'd0, busy, done}, 32'd0);
    alu_ctrl = 3'b010;
    #1;
    chk("ctrl010_stall", 32'(stall), 32'd0);
    tick();
    chk("ctrl010_busy", {30'd0, busy, done}, 32'd0);
    chk("ctrl_result_kept", result, 32'd1);
    start = 1'b0;
    $display("op ignored_ctrl busy=%0b done=%0b", busy, done);

    // start pulses during RUN must not re-latch operands
    run_op("div_poke", 3'b011, 32'd100, 32'd7, 32'd14, 33, 1'b0, 1'b1);
    run_op("div_1000_33", 3'b011, 32'd1000, 32'd33, 32'd30, 33, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound, in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
